// File: rtl/keystroke_sequencer_if.sv
// keystroke_sequencer_if: scan-code input strobe and word hand-off channel.
// The slave modport is the sequencer; the master is the byte source plus
// the word consumer.
interface keystroke_sequencer_if #(
  parameter int DEPTH = 8
);
  logic                 code_valid;
  logic [7:0]           code;
  logic                 word_valid;
  logic                 word_ready;
  logic [DEPTH*5-1:0]   word_data;
  logic [4:0]           word_len;

  modport master (
    output code_valid, code, word_ready,
    input  word_valid, word_data, word_len
  );

  modport slave (
    input  code_valid, code, word_ready,
    output word_valid, word_data, word_len
  );
endinterface

// File: rtl/keystroke_sequencer.sv
// keystroke_sequencer: strips PS/2 break (F0) and extended (E0) prefixes,
// dispatches legal make codes to the external keycode decoder as two
// nibbles, and collects decoded letters into a word released on Enter.
// Optional feature macro: KEYSEQ_BACKSPACE_EN (scan code 66 deletes the
// last buffered letter).
module keystroke_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  keystroke_sequencer_if.slave bus,
  output logic [3:0]          dig1,
  output logic [3:0]          dig2,
  input  logic [4:0]          letter,
  output logic                overflow
);
  localparam logic [1:0] NORM   = 2'd0;
  localparam logic [1:0] BRK    = 2'd1;
  localparam logic [1:0] EXT    = 2'd2;
  localparam logic [1:0] EXTBRK = 2'd3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SAMPLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [4:0] DEPTH_L = 5'(DEPTH);
  localparam logic [4:0] ENTER   = 5'd31;

  logic [1:0] prefix_reg;
  logic [1:0] ctl_reg;
  logic [4:0] len_reg;
  logic       valid_reg;

  // Make codes that the decoder maps to a letter or Enter; anything else
  // must never reach it because it would just repeat its last result.
  function automatic logic is_letter_code(input logic [7:0] c);
    case (c)
      8'h15, 8'h1D, 8'h1C, 8'h1B, 8'h1A, 8'h24, 8'h2D, 8'h2C, 8'h23,
      8'h2B, 8'h22, 8'h21, 8'h2A, 8'h35, 8'h3C, 8'h34, 8'h33, 8'h3B,
      8'h32, 8'h31, 8'h3A, 8'h43, 8'h44, 8'h4D, 8'h42, 8'h4B, 8'h5A:
        is_letter_code = 1'b1;
      default:
        is_letter_code = 1'b0;
    endcase
  endfunction

  logic is_f0;
  logic is_e0;
  logic is_bksp;
  logic make_cand;
  logic dispatch;
  logic bksp_take;
  logic is_alpha;
  logic store;
  logic drop_full;
  logic enter_take;
  logic accept;

  assign is_f0     = (bus.code == 8'hF0);
  assign is_e0     = (bus.code == 8'hE0);
  assign make_cand = bus.code_valid && (prefix_reg == NORM) && !is_f0 && !is_e0;

`ifdef KEYSEQ_BACKSPACE_EN
  assign is_bksp   = (bus.code == 8'h66);
`else
  assign is_bksp   = 1'b0;
`endif

  assign dispatch   = make_cand && (ctl_reg == IDLE) && is_letter_code(bus.code);
  assign bksp_take  = make_cand && (ctl_reg == IDLE) && is_bksp && (len_reg != 5'd0);
  assign is_alpha   = (letter < 5'd26);
  assign store      = (ctl_reg == SAMPLE) && is_alpha && (len_reg < DEPTH_L);
  assign drop_full  = (ctl_reg == SAMPLE) && is_alpha && (len_reg == DEPTH_L);
  assign enter_take = (ctl_reg == SAMPLE) && (letter == ENTER) && (len_reg != 5'd0);
  assign accept     = (ctl_reg == HOLD) && valid_reg && bus.word_ready;

  // Prefix tracker: runs on every byte regardless of the control state so
  // break/extended sequences stay aligned even while a word is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefix_reg <= NORM;
    end else if (bus.code_valid) begin
      case (prefix_reg)
        NORM:    prefix_reg <= is_f0 ? BRK : (is_e0 ? EXT : NORM);
        EXT:     prefix_reg <= is_f0 ? EXTBRK : NORM;
        BRK,
        EXTBRK:  prefix_reg <= NORM;
        default: prefix_reg <= NORM;
      endcase
    end
  end

  // Control: dispatch to decoder, sample its answer one cycle later, then
  // either buffer the letter or hold the finished word until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_reg   <= IDLE;
      dig1      <= 4'd0;
      dig2      <= 4'd0;
      len_reg   <= 5'd0;
      valid_reg <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= drop_full;
      case (ctl_reg)
        IDLE: begin
          if (dispatch) begin
            dig2    <= bus.code[7:4];
            dig1    <= bus.code[3:0];
            ctl_reg <= SAMPLE;
          end else if (bksp_take) begin
            len_reg <= len_reg - 5'd1;
          end
        end
        SAMPLE: begin
          ctl_reg <= IDLE;
          if (enter_take) begin
            ctl_reg   <= HOLD;
            valid_reg <= 1'b1;
          end else if (store) begin
            len_reg <= len_reg + 5'd1;
          end
        end
        HOLD: begin
          if (accept) begin
            valid_reg <= 1'b0;
            len_reg   <= 5'd0;
            ctl_reg   <= IDLE;
          end
        end
        default: ctl_reg <= IDLE;
      endcase
    end
  end

  // Letter slots: each one loads when it is the next free position and is
  // cleared when it is the one vacated by a backspace or on word hand-off.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [4:0] slot_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= 5'd0;
      end else if (accept) begin
        slot_reg <= 5'd0;
      end else if (store && (len_reg == 5'(gi))) begin
        slot_reg <= letter;
      end else if (bksp_take && (len_reg == 5'(gi + 1))) begin
        slot_reg <= 5'd0;
      end
    end

    assign bus.word_data[gi*5 +: 5] = slot_reg;
  end

  assign bus.word_valid = valid_reg;
  assign bus.word_len   = len_reg;
endmodule

// File: tb/tb_keystroke_sequencer.sv
// tb_keystroke_sequencer: table-driven scenario vectors, hand-written
// latency/overflow/reset sequences, and randomized byte streams checked
// against a word-level reference model. Emulates the keycode decoder.
module tb_keystroke_sequencer;
  localparam int DEPTH = 4;
  localparam int DW    = DEPTH * 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [4:0] letter;
  logic       overflow;

  always #5 clk = ~clk;

  keystroke_sequencer_if #(.DEPTH(DEPTH)) bus ();

  keystroke_sequencer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dig1     (dig1),
    .dig2     (dig2),
    .letter   (letter),
    .overflow (overflow)
  );

  // decoder emulation: standard set-2 letter codes, 5A = Enter
  logic [4:0] dec_lut [256];
  bit         legal   [256];
  logic [7:0] keys    [26];

  assign letter = dec_lut[{dig2, dig1}];

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  int ovf_base = 0;
  bit bksp_en;

  always @(negedge clk) if (overflow) ovf_seen++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] e_dig, input logic [4:0] e_len,
                             input logic e_wv, input logic [DW-1:0] e_data, input int e_ovf);
    check({tag, ".dig"},  {56'd0, dig2, dig1}, {56'd0, e_dig});
    check({tag, ".len"},  {59'd0, bus.word_len}, {59'd0, e_len});
    check({tag, ".wv"},   {63'd0, bus.word_valid}, {63'd0, e_wv});
    check({tag, ".data"}, {{(64-DW){1'b0}}, bus.word_data}, {{(64-DW){1'b0}}, e_data});
    check({tag, ".ovf"},  64'(ovf_seen - ovf_base), 64'(e_ovf));
  endtask

  // ---------------- reference model (word level) ----------------
  logic [4:0] m_q[$];
  bit         m_hold;
  bit         m_brk;
  bit         m_ext;
  logic [7:0] m_dig;
  int         m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_hold = 0; m_brk = 0; m_ext = 0; m_dig = 8'h00; m_ovf = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [4:0] l;
    if (m_brk) begin m_brk = 0; m_ext = 0; return; end   // released key
    if (m_ext) begin m_ext = 0; if (b == 8'hF0) m_brk = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (m_hold) return;                                   // word waiting
    if (bksp_en && b == 8'h66) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
      return;
    end
    if (!legal[b]) return;
    m_dig = b;
    l = dec_lut[b];
    if (l == 5'd31) begin
      if (m_q.size() > 0) m_hold = 1;
    end else if (m_q.size() < DEPTH) begin
      m_q.push_back(l);
    end else begin
      m_ovf++;
    end
  endtask

  task automatic model_ready();
    if (m_hold) begin m_q.delete(); m_hold = 0; end
  endtask

  function automatic logic [DW-1:0] model_data();
    logic [DW-1:0] d = '0;
    foreach (m_q[i]) d[i*5 +: 5] = m_q[i];
    return d;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk); bus.code_valid = 1'b1; bus.code = b;
    @(negedge clk); bus.code_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ready_pulse();
    @(negedge clk); bus.word_ready = 1'b1;
    @(negedge clk); bus.word_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    ovf_base = ovf_seen;
  endtask

  typedef struct {
    bit         rdy;
    logic [7:0] code;
    logic [7:0] dig;
    logic [4:0] len;
    bit         wv;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    for (int i = 0; i < 256; i++) begin dec_lut[i] = 5'd0; legal[i] = 0; end
    for (int i = 0; i < 26; i++) begin dec_lut[keys[i]] = 5'(i); legal[keys[i]] = 1; end
    dec_lut[8'h5A] = 5'd31; legal[8'h5A] = 1;
`ifdef KEYSEQ_BACKSPACE_EN
    bksp_en = 1;
`else
    bksp_en = 0;
`endif
    bus.code_valid = 1'b0; bus.code = 8'h00; bus.word_ready = 1'b0;
    model_reset();

    // rdy, code, dig, len, wv, data
    vecs.push_back('{0, 8'h1C, 8'h1C, 5'd1, 0, 20'h00000});
    vecs.push_back('{0, 8'hF0, 8'h1C, 5'd1, 0, 20'h00000});
    vecs.push_back('{0, 8'h1C, 8'h1C, 5'd1, 0, 20'h00000});
    vecs.push_back('{0, 8'h32, 8'h32, 5'd2, 0, 20'h00020});
    vecs.push_back('{0, 8'hF0, 8'h32, 5'd2, 0, 20'h00020});
    vecs.push_back('{0, 8'h32, 8'h32, 5'd2, 0, 20'h00020});
    vecs.push_back('{0, 8'h5A, 8'h5A, 5'd2, 1, 20'h00020});
    vecs.push_back('{0, 8'hF0, 8'h5A, 5'd2, 1, 20'h00020});
    vecs.push_back('{0, 8'h5A, 8'h5A, 5'd2, 1, 20'h00020});
    vecs.push_back('{1, 8'h00, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'h15, 8'h15, 5'd1, 0, 20'h00010});
    vecs.push_back('{0, 8'h5A, 8'h5A, 5'd1, 1, 20'h00010});
    vecs.push_back('{1, 8'h00, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'hE0, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'h75, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'hE0, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'hF0, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'h75, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'h29, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'hE0, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'h1C, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'h5A, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'h1C, 8'h1C, 5'd1, 0, 20'h00000});
    vecs.push_back('{0, 8'h5A, 8'h5A, 5'd1, 1, 20'h00000});
    vecs.push_back('{0, 8'hF0, 8'h5A, 5'd1, 1, 20'h00000});
    vecs.push_back('{0, 8'h1C, 8'h5A, 5'd1, 1, 20'h00000});
    vecs.push_back('{0, 8'h32, 8'h5A, 5'd1, 1, 20'h00000});
    vecs.push_back('{1, 8'h00, 8'h5A, 5'd0, 0, 20'h00000});
    vecs.push_back('{0, 8'h1C, 8'h1C, 5'd1, 0, 20'h00000});
    vecs.push_back('{1, 8'h00, 8'h1C, 5'd1, 0, 20'h00000});

    // reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("reset", 8'h00, 5'd0, 0, '0, 0);
    check("reset.overflow", {63'd0, overflow}, 64'd0);

    // table-driven scenario vectors
    foreach (vecs[i]) begin
      if (vecs[i].rdy) ready_pulse(); else send(vecs[i].code);
      check_state($sformatf("vec%0d", i), vecs[i].dig, vecs[i].len, vecs[i].wv, vecs[i].data, 0);
      $display("vec %0d rdy=%0d code=%h len=%0d wv=%0d", i, vecs[i].rdy, vecs[i].code,
               bus.word_len, bus.word_valid);
    end

    // asynchronous reset while three letters are buffered
    send(8'h32);
    send(8'h21);
    check("pre_rst.len", {59'd0, bus.word_len}, 64'd3);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 8'h00, 5'd0, 0, '0, 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset(); ovf_base = ovf_seen;
    $display("async reset mid-word checked");

    // letter latency: dig at N+1, word_len at N+2
    @(negedge clk); bus.code_valid = 1'b1; bus.code = 8'h1C;
    @(negedge clk); bus.code_valid = 1'b0;
    check("lat.dig_n1", {56'd0, dig2, dig1}, 64'h1C);
    check("lat.len_n1", {59'd0, bus.word_len}, 64'd0);
    @(negedge clk);
    check("lat.len_n2", {59'd0, bus.word_len}, 64'd1);
    repeat (2) @(negedge clk);

    // fill to DEPTH, then one more: single overflow pulse, cycle after SAMPLE
    for (int i = 1; i < DEPTH; i++) send(8'h1C);
    check("fill.len", {59'd0, bus.word_len}, 64'(DEPTH));
    check("fill.ovf", 64'(ovf_seen - ovf_base), 64'd0);
    @(negedge clk); bus.code_valid = 1'b1; bus.code = 8'h1C;
    @(negedge clk); bus.code_valid = 1'b0;
    check("ovf.sample", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    check("ovf.pulse", {63'd0, overflow}, 64'd1);
    @(negedge clk);
    check("ovf.after", {63'd0, overflow}, 64'd0);
    check("ovf.len", {59'd0, bus.word_len}, 64'(DEPTH));
    repeat (2) @(negedge clk);
    check("ovf.count", 64'(ovf_seen - ovf_base), 64'd1);
    $display("overflow sequence done len=%0d", bus.word_len);

    // Enter latency: word_valid from N+2
    @(negedge clk); bus.code_valid = 1'b1; bus.code = 8'h5A;
    @(negedge clk); bus.code_valid = 1'b0;
    check("ent.wv_n1", {63'd0, bus.word_valid}, 64'd0);
    @(negedge clk);
    check("ent.wv_n2", {63'd0, bus.word_valid}, 64'd1);
    ready_pulse();
    check("ent.cleared", {59'd0, bus.word_len}, 64'd0);

    // make arriving during SAMPLE is dropped
    @(negedge clk); bus.code_valid = 1'b1; bus.code = 8'h32;
    @(negedge clk); bus.code = 8'h21;
    @(negedge clk); bus.code_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b.len", {59'd0, bus.word_len}, 64'd1);
    check("b2b.dig", {56'd0, dig2, dig1}, 64'h32);
    check("b2b.data", {{(64-DW){1'b0}}, bus.word_data}, 64'h1);
    $display("back-to-back make checked");

    // backspace code 66
    do_reset();
    send(8'h1C); send(8'h32); send(8'h66);
    if (bksp_en) check_state("bksp", 8'h32, 5'd1, 0, 20'h00000, 0);
    else         check_state("bksp", 8'h32, 5'd2, 0, 20'h00020, 0);
    $display("code 66 handled len=%0d", bus.word_len);

    // randomized byte streams against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [7:0] b;
      sel = int'($urandom_range(0, 99));
      if (sel < 10) begin
        ready_pulse();
        model_ready();
        $display("rnd %0d ready len=%0d wv=%0d", n, bus.word_len, bus.word_valid);
      end else begin
        if (sel < 50)      b = keys[$urandom_range(0, 25)];
        else if (sel < 60) b = 8'h5A;
        else if (sel < 72) b = 8'hF0;
        else if (sel < 80) b = 8'hE0;
        else if (sel < 86) b = 8'h66;
        else               b = 8'($urandom_range(0, 255));
        send(b);
        model_byte(b);
        $display("rnd %0d code=%h len=%0d wv=%0d", n, b, bus.word_len, bus.word_valid);
      end
      check_state($sformatf("rnd%0d", n), m_dig, 5'(m_q.size()), m_hold, model_data(), m_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
